// File: rtl/regs_pkg.sv
// rtl/regs_pkg.sv - shared widths, zero-register index and FSM state encoding
// Ports: none (package). Provides XLEN, AW, ZERO_REG and state_t.
package regs_pkg;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   // Architectural zero register: reads as 0, writes are dropped.
   localparam logic [AW-1:0] ZERO_REG = '0;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RS1  = 3'd1,
      RS2  = 3'd2,
      RSP  = 3'd3,
      WB   = 3'd4
   } state_t;

endpackage

// File: rtl/regs_seq_if.sv
// rtl/regs_seq_if.sv - operand-read, response, writeback and register-file bundle
// Ports (signals):
//   req_valid/req_ready/req_rs1/req_rs2  operand-read request
//   rsp_valid/rsp_ready/rsp_op1/rsp_op2  operand response
//   wb_valid/wb_ready/wb_rd/wb_data      writeback request
//   rf_addr/rf_we/rf_wdata/rf_rdata      single-port register file
// Modports: master = surrounding core and register file, slave = regs_seq.
interface regs_seq_if #(
   parameter int XLEN = regs_pkg::XLEN,
   parameter int AW   = regs_pkg::AW
);

   logic            req_valid;
   logic            req_ready;
   logic [AW-1:0]   req_rs1;
   logic [AW-1:0]   req_rs2;

   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_op1;
   logic [XLEN-1:0] rsp_op2;

   logic            wb_valid;
   logic            wb_ready;
   logic [AW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;

   logic [AW-1:0]   rf_addr;
   logic            rf_we;
   logic [XLEN-1:0] rf_wdata;
   logic [XLEN-1:0] rf_rdata;

   modport master (
      output req_valid, req_rs1, req_rs2,
      output rsp_ready,
      output wb_valid, wb_rd, wb_data,
      output rf_rdata,
      input  req_ready, rsp_valid, rsp_op1, rsp_op2,
      input  wb_ready, rf_addr, rf_we, rf_wdata
   );

   modport slave (
      input  req_valid, req_rs1, req_rs2,
      input  rsp_ready,
      input  wb_valid, wb_rd, wb_data,
      input  rf_rdata,
      output req_ready, rsp_valid, rsp_op1, rsp_op2,
      output wb_ready, rf_addr, rf_we, rf_wdata
   );

endinterface

// File: rtl/regs_arb2.sv
// rtl/regs_arb2.sv - two-way round-robin grant with a single priority bit
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   valid0, valid1  requesters (side 0 wins the first contest after reset)
//   en              grants are only issued while en is high
//   gnt0, gnt1      one-hot-or-zero grants, combinational from the inputs
module regs_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic valid0,
   input  logic valid1,
   input  logic en,
   output logic gnt0,
   output logic gnt1
);

   // 0: side 0 wins a contest, 1: side 1 wins a contest.
   logic prio1;

   logic contested;
   assign contested = en && valid0 && valid1;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (en) begin
         if (valid0 && valid1) begin
            gnt0 = !prio1;
            gnt1 = prio1;
         end else begin
            gnt0 = valid0;
            gnt1 = valid1;
         end
      end
   end

   // A grant is always taken (the granted side is valid), so every
   // contested cycle is a contested grant and hands priority over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio1 <= 1'b0;
      end else if (contested) begin
         prio1 <= !prio1;
      end
   end

endmodule

// File: rtl/regs_seq.sv
// rtl/regs_seq.sv - sequences operand reads and writebacks over one register-file port
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    regs_seq_if.slave: req/rsp/wb handshakes and register-file port
// A read walks IDLE->RS1->RS2->RSP (4 cycles minimum), a writeback
// IDLE->WB (2 cycles). Only IDLE accepts work, so reads and writes are
// strictly ordered by grant.
module regs_seq #(
   parameter int XLEN = regs_pkg::XLEN,
   parameter int AW   = regs_pkg::AW
) (
   input  logic       clk,
   input  logic       rst_n,
   regs_seq_if.slave  bus
);

   import regs_pkg::*;

   state_t          state;

   logic [AW-1:0]   rs1_q;
   logic [AW-1:0]   rs2_q;
   logic [XLEN-1:0] op1_q;
   logic [XLEN-1:0] op2_q;
   logic            rsp_valid_q;

   // Register-file drive is registered and loaded on the transition into
   // the state that uses it, so it is glitch-free and zero outside RS/WB.
   logic [AW-1:0]   rf_addr_q;
   logic            rf_we_q;
   logic [XLEN-1:0] rf_wdata_q;

   logic            arb_en;
   logic            gnt_wb;
   logic            gnt_req;

   // Gated by rst_n so neither ready can rise while reset is held.
   assign arb_en = (state == IDLE) && rst_n;

   regs_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid0 (bus.wb_valid),
      .valid1 (bus.req_valid),
      .en     (arb_en),
      .gnt0   (gnt_wb),
      .gnt1   (gnt_req)
   );

   assign bus.wb_ready  = gnt_wb;
   assign bus.req_ready = gnt_req;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_op1   = op1_q;
   assign bus.rsp_op2   = op2_q;
   assign bus.rf_addr   = rf_addr_q;
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_wdata  = rf_wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rs1_q       <= '0;
         rs2_q       <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         rsp_valid_q <= 1'b0;
         rf_addr_q   <= '0;
         rf_we_q     <= 1'b0;
         rf_wdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_wb) begin
                  state      <= WB;
                  rf_addr_q  <= bus.wb_rd;
                  rf_wdata_q <= bus.wb_data;
                  // Writes to the zero register are accepted but dropped.
                  rf_we_q    <= (bus.wb_rd != AW'(ZERO_REG));
               end else if (gnt_req) begin
                  state     <= RS1;
                  rs1_q     <= bus.req_rs1;
                  rs2_q     <= bus.req_rs2;
                  rf_addr_q <= bus.req_rs1;
               end
            end

            RS1: begin
               op1_q     <= (rs1_q == AW'(ZERO_REG)) ? '0 : bus.rf_rdata;
               rf_addr_q <= rs2_q;
               state     <= RS2;
            end

            RS2: begin
               op2_q       <= (rs2_q == AW'(ZERO_REG)) ? '0 : bus.rf_rdata;
               rf_addr_q   <= '0;
               rsp_valid_q <= 1'b1;
               state       <= RSP;
            end

            RSP: begin
               // Operands hold until the consumer takes them.
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end

            WB: begin
               rf_addr_q  <= '0;
               rf_wdata_q <= '0;
               rf_we_q    <= 1'b0;
               state      <= IDLE;
            end

            default: begin
               state       <= IDLE;
               rsp_valid_q <= 1'b0;
               rf_addr_q   <= '0;
               rf_we_q     <= 1'b0;
               rf_wdata_q  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regs_seq.sv
// tb/tb_regs_seq.sv - directed self-checking bench for regs_seq
// Ports: none (top-level bench).
module tb_regs_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int total = 0;
   int bad   = 0;

   regs_seq_if #(.XLEN(32), .AW(5)) bus ();

   regs_seq u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Register file: combinational read, write on the clock edge.
   // Unwritten entries (including r0) hold a non-zero pattern.
   logic [31:0] rf_mem [32] = '{default: 32'hA5A5_0000};
   assign bus.rf_rdata = rf_mem[bus.rf_addr];
   always @(posedge clk) begin
      if (bus.rf_we) rf_mem[bus.rf_addr] <= bus.rf_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   // Uncontested read from IDLE, response taken immediately.
   task automatic read_op(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] exp1, input logic [31:0] exp2,
                          input string tag);
      bus.req_valid = 1'b1;
      bus.req_rs1   = rs1;
      bus.req_rs2   = rs2;
      settle();
      check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
      step();
      bus.req_valid = 1'b0;
      check({tag, "_rs1_addr"}, 32'(bus.rf_addr), 32'(rs1));
      check({tag, "_rs1_novalid"}, 32'(bus.rsp_valid), 32'd0);
      step();
      check({tag, "_rs2_addr"}, 32'(bus.rf_addr), 32'(rs2));
      step();
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_op1"}, bus.rsp_op1, exp1);
      check({tag, "_op2"}, bus.rsp_op2, exp2);
      check({tag, "_rsp_addr0"}, 32'(bus.rf_addr), 32'd0);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      check({tag, "_rsp_done"}, 32'(bus.rsp_valid), 32'd0);
   endtask

   logic [7:0] rv_seen;
   logic [7:0] rr_seen;

   initial begin
      bus.req_valid = 1'b1;
      bus.req_rs1   = '0;
      bus.req_rs2   = '0;
      bus.rsp_ready = 1'b0;
      bus.wb_valid  = 1'b1;
      bus.wb_rd     = '0;
      bus.wb_data   = '0;
      rv_seen       = '0;
      rr_seen       = '0;

      // Reset state, both requesters valid while reset is held.
      step();
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_wb_ready", 32'(bus.wb_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rf_we", 32'(bus.rf_we), 32'd0);
      check("rst_rf_addr", 32'(bus.rf_addr), 32'd0);
      check("rst_op1", bus.rsp_op1, 32'd0);
      bus.req_valid = 1'b0;
      bus.wb_valid  = 1'b0;
      step();
      rst_n = 1'b1;

      // Write 0xDEADBEEF to r5, then read r5/r0.
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd5;
      bus.wb_data  = 32'hDEAD_BEEF;
      settle();
      check("wb1_ready", 32'(bus.wb_ready), 32'd1);
      check("wb1_req_ready", 32'(bus.req_ready), 32'd0);
      step();
      bus.wb_valid = 1'b0;
      check("wb1_we", 32'(bus.rf_we), 32'd1);
      check("wb1_addr", 32'(bus.rf_addr), 32'd5);
      check("wb1_wdata", bus.rf_wdata, 32'hDEAD_BEEF);
      check("wb1_busy_ready", 32'(bus.wb_ready), 32'd0);
      step();
      check("wb1_we_done", 32'(bus.rf_we), 32'd0);
      check("wb1_idle_wdata", bus.rf_wdata, 32'd0);
      read_op(5'd5, 5'd0, 32'hDEAD_BEEF, 32'd0, "rd1");

      // Contested grants: wb first after reset, then alternate.
      bus.wb_valid  = 1'b1;
      bus.wb_rd     = 5'd7;
      bus.wb_data   = 32'h1111_1111;
      bus.req_valid = 1'b1;
      bus.req_rs1   = 5'd7;
      bus.req_rs2   = 5'd5;
      settle();
      check("arb1_wb", 32'(bus.wb_ready), 32'd1);
      check("arb1_req", 32'(bus.req_ready), 32'd0);
      step();
      bus.wb_data = 32'h2222_2222;
      check("arb1_wb_busy", 32'(bus.wb_ready), 32'd0);
      check("arb1_req_busy", 32'(bus.req_ready), 32'd0);
      check("arb1_we", 32'(bus.rf_we), 32'd1);
      step();
      check("arb2_req", 32'(bus.req_ready), 32'd1);
      check("arb2_wb", 32'(bus.wb_ready), 32'd0);
      step();
      step();
      step();
      check("arb2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("arb2_op1", bus.rsp_op1, 32'h1111_1111);
      check("arb2_op2", bus.rsp_op2, 32'hDEAD_BEEF);
      check("arb2_wb_blocked", 32'(bus.wb_ready), 32'd0);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      check("arb3_wb", 32'(bus.wb_ready), 32'd1);
      check("arb3_req", 32'(bus.req_ready), 32'd0);
      step();
      bus.wb_valid  = 1'b0;
      bus.req_valid = 1'b0;
      step();
      read_op(5'd7, 5'd7, 32'h2222_2222, 32'h2222_2222, "rd2");

      // Writeback to r0 is accepted with no write strobe.
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd0;
      bus.wb_data  = 32'h1234_5678;
      settle();
      check("wb0_ready", 32'(bus.wb_ready), 32'd1);
      step();
      bus.wb_valid = 1'b0;
      check("wb0_we", 32'(bus.rf_we), 32'd0);
      check("wb0_busy_ready", 32'(bus.wb_ready), 32'd0);
      step();
      check("wb0_we_after", 32'(bus.rf_we), 32'd0);
      read_op(5'd0, 5'd0, 32'd0, 32'd0, "rd0");

      // Response stall: everything holds, no grants.
      bus.req_valid = 1'b1;
      bus.req_rs1   = 5'd5;
      bus.req_rs2   = 5'd7;
      settle();
      check("stall_fire", 32'(bus.req_ready), 32'd1);
      step();
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd3;
      bus.wb_data  = 32'h3333_3333;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check("stall_op1", bus.rsp_op1, 32'hDEAD_BEEF);
         check("stall_op2", bus.rsp_op2, 32'h2222_2222);
         check("stall_req_ready", 32'(bus.req_ready), 32'd0);
         check("stall_wb_ready", 32'(bus.wb_ready), 32'd0);
         step();
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      check("stall_done", 32'(bus.rsp_valid), 32'd0);
      check("arb4_req", 32'(bus.req_ready), 32'd1);
      check("arb4_wb", 32'(bus.wb_ready), 32'd0);
      bus.req_valid = 1'b0;
      bus.wb_valid  = 1'b0;
      settle();

      // Reset during RS2 aborts the read.
      bus.req_valid = 1'b1;
      bus.req_rs1   = 5'd5;
      bus.req_rs2   = 5'd5;
      settle();
      check("ab_fire", 32'(bus.req_ready), 32'd1);
      step();
      bus.req_valid = 1'b0;
      step();
      check("ab_rs2_addr", 32'(bus.rf_addr), 32'd5);
      check("ab_op1_loaded", bus.rsp_op1, 32'hDEAD_BEEF);
      rst_n = 1'b0;
      settle();
      check("ab_op1", bus.rsp_op1, 32'd0);
      check("ab_addr", 32'(bus.rf_addr), 32'd0);
      check("ab_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("ab_we", 32'(bus.rf_we), 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("ab_no_rsp", 32'(bus.rsp_valid), 32'd0);
         check("ab_no_we", 32'(bus.rf_we), 32'd0);
      end
      bus.wb_valid  = 1'b1;
      bus.req_valid = 1'b1;
      settle();
      check("ab_prio_wb", 32'(bus.wb_ready), 32'd1);
      check("ab_prio_req", 32'(bus.req_ready), 32'd0);
      bus.wb_valid  = 1'b0;
      bus.req_valid = 1'b0;
      settle();

      // Back-to-back reads with req_valid held high.
      bus.req_valid = 1'b1;
      bus.req_rs1   = 5'd5;
      bus.req_rs2   = 5'd7;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         settle();
         rv_seen[k] = bus.rsp_valid;
         rr_seen[k] = bus.req_ready;
         if (bus.rsp_valid) check("b2b_op1", bus.rsp_op1, 32'hDEAD_BEEF);
         step();
      end
      check("b2b_rsp_pattern", 32'(rv_seen), 32'h88);
      check("b2b_ready_pattern", 32'(rr_seen), 32'h11);
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd5;
      bus.wb_data  = 32'hCAFE_F00D;
      settle();
      check("b2b_wb_grant", 32'(bus.wb_ready), 32'd1);
      check("b2b_req_wait", 32'(bus.req_ready), 32'd0);
      step();
      bus.wb_valid = 1'b0;
      step();
      settle();
      check("b2b_req_again", 32'(bus.req_ready), 32'd1);
      step();
      step();
      step();
      check("b2b_rsp2_valid", 32'(bus.rsp_valid), 32'd1);
      check("b2b_new_op1", bus.rsp_op1, 32'hCAFE_F00D);
      check("b2b_new_op2", bus.rsp_op2, 32'h2222_2222);
      bus.req_valid = 1'b0;
      step();
      bus.rsp_ready = 1'b0;
      check("b2b_end", 32'(bus.rsp_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
